// File: rtl/pipe_pkg.sv
// Shared types for the pipe_issuer slice: default widths, issuer FSM states, operand quadruple.
// The operand struct is sized from W_DEF, so the issuer's W parameter must stay equal to W_DEF.
package pipe_pkg;

  localparam int W_DEF   = 32;
  localparam int LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [W_DEF-1:0] a1;
    logic [W_DEF-1:0] b1;
    logic [W_DEF-1:0] a2;
    logic [W_DEF-1:0] b2;
  } op_t;

endpackage

// File: rtl/pipe_issuer_if.sv
// Upstream operand-quadruple handshake into pipe_issuer; in_ready depends only on FIFO fullness.
interface pipe_issuer_if #(
  parameter int W = pipe_pkg::W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a1;
  logic [W-1:0] in_b1;
  logic [W-1:0] in_a2;
  logic [W-1:0] in_b2;

  modport master (
    output in_valid, in_a1, in_b1, in_a2, in_b2,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a1, in_b1, in_a2, in_b2,
    output in_ready
  );

endinterface

// File: rtl/pipe_fifo.sv
// Synchronous DEPTH x DW FIFO, head visible combinationally; push ignored when full, pop when empty.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module pipe_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wr_dat,
  input  logic                     pop,
  output logic [DW-1:0]            rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_dat  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/pipe_issuer.sv
// Buffers operand quadruples, issues one per clock to the MAC pipeline, captures results LAT+2 edges
// after acceptance into an empty FIFO; upstream stalls only on a full FIFO, results never stall.
module pipe_issuer
  import pipe_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 4,
  parameter int LAT   = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pipe_issuer_if.slave  up,
  input  logic          issue_hold,
  output logic [W-1:0]  pipe_a1,
  output logic [W-1:0]  pipe_b1,
  output logic [W-1:0]  pipe_a2,
  output logic [W-1:0]  pipe_b2,
  input  logic [W-1:0]  pipe_c,
  output logic          res_valid,
  output logic [W-1:0]  res_c,
  output logic [15:0]   res_count,
  output logic          busy
);

  localparam int LW = $clog2(DEPTH) + 1;

  op_t           wr_op, head_op;
  op_t           pipe_q, pipe_d;
  logic          full, empty, push, pop;
  logic [LW-1:0] level;

  // Bit 0 marks valid operands on pipe_*; bit k marks work k cycles into the pipeline.
  logic [LAT:0]  vsr_q, vsr_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_c_q, res_c_d;
  logic [15:0]   res_count_q, res_count_d;
  state_t        state_q, state_d;

  assign up.in_ready = !full;
  assign push        = up.in_valid && !full;
  assign pop         = !empty && !issue_hold;
  assign wr_op       = {up.in_a1, up.in_b1, up.in_a2, up.in_b2};

  pipe_fifo #(
    .DW    ($bits(op_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_dat (wr_op),
    .pop    (pop),
    .rd_dat (head_op),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_comb begin
    pipe_d      = pop ? head_op : '0;
    vsr_d       = {vsr_q[LAT-1:0], pop};
    res_valid_d = vsr_q[LAT];
    res_c_d     = vsr_q[LAT] ? pipe_c : res_c_q;
    res_count_d = res_count_q + {15'd0, vsr_q[LAT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q      <= '0;
      vsr_q       <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      res_count_q <= '0;
      state_q     <= IDLE;
    end else begin
      pipe_q      <= pipe_d;
      vsr_q       <= vsr_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      res_count_q <= res_count_d;
      state_q     <= state_d;
    end
  end

  // DRAIN is left only once vsr was already clear, so busy spans the capture cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push) state_d = ISSUE;
      ISSUE:   if (pop && !push && (level == LW'(1))) state_d = DRAIN;
      DRAIN: begin
        if (push)               state_d = ISSUE;
        else if (vsr_q == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign pipe_a1   = pipe_q.a1;
  assign pipe_b1   = pipe_q.b1;
  assign pipe_a2   = pipe_q.a2;
  assign pipe_b2   = pipe_q.b2;
  assign res_valid = res_valid_q;
  assign res_c     = res_c_q;
  assign res_count = res_count_q;

endmodule
